// File: rtl/rpmr_diag_pkg.sv
// RPMR (RPxx maintenance register) shared definitions: the bit map of the
// write data and readback, plus the helper that assembles the readback word.
package rpmr_diag_pkg;

  localparam int unsigned RPMR_DMD  = 0;
  localparam int unsigned RPMR_DCLK = 1;
  localparam int unsigned RPMR_DIND = 2;
  localparam int unsigned RPMR_DSCK = 3;
  localparam int unsigned RPMR_DDAT = 4;
  localparam int unsigned RPMR_ECE  = 6;
  localparam int unsigned RPMR_DFE  = 7;
  localparam int unsigned RPMR_CTL_W = 5;

  // Lanes of the rising-edge detector
  localparam int unsigned EDGE_CLK = 0;
  localparam int unsigned EDGE_IND = 1;
  localparam int unsigned EDGE_SCK = 2;
  localparam int unsigned EDGE_W   = 3;

  // Field order matches the bus bit map, so a cast of data[4:0] decodes it
  typedef struct packed {
    logic ddat;
    logic dsck;
    logic dind;
    logic dclk;
    logic dmd;
  } rpmr_ctl_t;

  function automatic rpmr_ctl_t rpmr_decode(input logic [RPMR_CTL_W-1:0] d);
    return rpmr_ctl_t'(d);
  endfunction

  function automatic logic [15:0] rpmr_pack(input logic [7:0] sect,
                                            input logic       dfe,
                                            input logic       ece,
                                            input rpmr_ctl_t  ctl);
    logic [15:0] w;
    w            = '0;
    w[15:8]      = sect;
    w[RPMR_DFE]  = dfe;
    w[RPMR_ECE]  = ece;
    w[RPMR_DDAT] = ctl.ddat;
    w[RPMR_DSCK] = ctl.dsck;
    w[RPMR_DIND] = ctl.dind;
    w[RPMR_DCLK] = ctl.dclk;
    w[RPMR_DMD]  = ctl.dmd;
    return w;
  endfunction

endpackage

// File: rtl/rpmr_diag_edge.sv
// Parametrised-width rising-edge detector: previous-value register plus
// AND-NOT, synchronous active-low reset.
module rpmr_edge #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/rpmr_diag.sv
// RPxx maintenance register with diagnostic datapath: mode bits, edge
// strobes, wrapping diagnostic sector counter and diagnostic shift register.
module rpmr_diag
  import rpmr_diag_pkg::*;
#(
  parameter int unsigned NSECT   = 20,
  parameter int unsigned SECT_W  = 5,
  parameter int unsigned SHIFT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               rpDRVCLR,
  input  logic [35:0]        rpDATAI,
  input  logic               rpmrWRITE,
  input  logic               rpDRY,
  input  logic               rpDFE,
  input  logic               rpECE,
  output logic [15:0]        rpMR,
  output logic [SECT_W-1:0]  rpDSECT,
  output logic [SHIFT_W-1:0] rpDSHIFT,
  output logic               rpDCLKP,
  output logic               rpDINDP,
  output logic               rpDSCKP,
  output logic               rpDWRAP
);

  localparam logic [SECT_W-1:0] SECT_LAST = SECT_W'(NSECT - 1);
  localparam logic [SECT_W-1:0] SECT_ONE  = SECT_W'(1);

  rpmr_ctl_t           w_wdat;
  rpmr_ctl_t           r_ctl;
  logic                w_clear;
  logic [EDGE_W-1:0]   w_rise;
  logic [EDGE_W-1:0]   w_strb_nxt;
  logic [EDGE_W-1:0]   r_strb;
  logic                w_wrap_nxt;
  logic                r_wrap;
  logic [SECT_W-1:0]   w_sect_nxt;
  logic [SECT_W-1:0]   r_sect;
  logic [SHIFT_W-1:0]  w_shift_nxt;
  logic [SHIFT_W-1:0]  r_shift;
  logic                w_unused;

  assign w_wdat   = rpmr_decode(rpDATAI[RPMR_CTL_W-1:0]);
  assign w_clear  = clr | rpDRVCLR;
  // DFE/ECE are readback-only here; their write bits and the upper bus bits are ignored
  assign w_unused = ^rpDATAI[35:RPMR_CTL_W];

  // DMD follows clear/write directly; the diagnostic bits are gated by the
  // already-registered DMD, so a DMD-setting write cannot load them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctl <= '0;
    end else begin
      if (w_clear)                 r_ctl.dmd <= 1'b0;
      else if (rpmrWRITE && rpDRY) r_ctl.dmd <= w_wdat.dmd;

      if (!r_ctl.dmd) begin
        r_ctl.dclk <= 1'b0;
        r_ctl.dind <= 1'b0;
        r_ctl.dsck <= 1'b0;
        r_ctl.ddat <= 1'b0;
      end else if (rpmrWRITE) begin
        r_ctl.dclk <= w_wdat.dclk;
        r_ctl.dind <= w_wdat.dind;
        r_ctl.dsck <= w_wdat.dsck;
        r_ctl.ddat <= w_wdat.ddat;
      end
    end
  end

  rpmr_edge #(
    .W (EDGE_W)
  ) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    ({r_ctl.dsck, r_ctl.dind, r_ctl.dclk}),
    .o_rise (w_rise)
  );

  always_comb begin
    w_strb_nxt  = '0;
    w_wrap_nxt  = 1'b0;
    w_sect_nxt  = r_sect;
    w_shift_nxt = r_shift;
    if (!r_ctl.dmd) begin
      w_sect_nxt  = '0;
      w_shift_nxt = '0;
    end else begin
      w_strb_nxt = w_rise;
      // Index has priority over a coincident sector edge and suppresses wrap
      if (w_rise[EDGE_IND]) begin
        w_sect_nxt = '0;
      end else if (w_rise[EDGE_SCK]) begin
        if (r_sect == SECT_LAST) begin
          w_sect_nxt = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_sect_nxt = r_sect + SECT_ONE;
        end
      end
      if (w_rise[EDGE_CLK]) w_shift_nxt = {r_shift[SHIFT_W-2:0], r_ctl.ddat};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_strb  <= '0;
      r_wrap  <= 1'b0;
      r_sect  <= '0;
      r_shift <= '0;
    end else begin
      r_strb  <= w_strb_nxt;
      r_wrap  <= w_wrap_nxt;
      r_sect  <= w_sect_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign rpMR     = rpmr_pack(8'(r_sect), rpDFE, rpECE, r_ctl);
  assign rpDSECT  = r_sect;
  assign rpDSHIFT = r_shift;
  assign rpDCLKP  = r_strb[EDGE_CLK];
  assign rpDINDP  = r_strb[EDGE_IND];
  assign rpDSCKP  = r_strb[EDGE_SCK];
  assign rpDWRAP  = r_wrap;

endmodule

// File: tb/tb_rpmr_diag.sv
// Self-checking bench for rpmr_diag: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_rpmr_diag;

  localparam int NSECT   = 20;
  localparam int SECT_W  = 5;
  localparam int SHIFT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n, clr, rpDRVCLR, rpmrWRITE, rpDRY, rpDFE, rpECE;
  logic [35:0]        rpDATAI;
  logic [15:0]        rpMR;
  logic [SECT_W-1:0]  rpDSECT;
  logic [SHIFT_W-1:0] rpDSHIFT;
  logic               rpDCLKP, rpDINDP, rpDSCKP, rpDWRAP;

  always #5 clk = ~clk;

  rpmr_diag #(
    .NSECT   (NSECT),
    .SECT_W  (SECT_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .rpDRVCLR  (rpDRVCLR),
    .rpDATAI   (rpDATAI),
    .rpmrWRITE (rpmrWRITE),
    .rpDRY     (rpDRY),
    .rpDFE     (rpDFE),
    .rpECE     (rpECE),
    .rpMR      (rpMR),
    .rpDSECT   (rpDSECT),
    .rpDSHIFT  (rpDSHIFT),
    .rpDCLKP   (rpDCLKP),
    .rpDINDP   (rpDINDP),
    .rpDSCKP   (rpDSCKP),
    .rpDWRAP   (rpDWRAP)
  );

  int total = 0;
  int bad   = 0;
  int n_clkp, n_wrap;

  // Model: register bits as software sees them, the value each edge-tracked
  // bit had one cycle earlier, and the diagnostic counters as plain integers.
  bit m_dmd, m_dclk, m_dind, m_dsck, m_ddat;
  bit p_dclk, p_dind, p_dsck;
  int m_sect, m_shift;
  bit s_clk, s_ind, s_sck, s_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rc, ri, rs;
    if (!rst_n) begin
      m_dmd = 0; m_dclk = 0; m_dind = 0; m_dsck = 0; m_ddat = 0;
      p_dclk = 0; p_dind = 0; p_dsck = 0;
      m_sect = 0; m_shift = 0;
      s_clk = 0; s_ind = 0; s_sck = 0; s_wrap = 0;
      return;
    end
    rc = m_dclk && !p_dclk;
    ri = m_dind && !p_dind;
    rs = m_dsck && !p_dsck;
    s_clk  = m_dmd && rc;
    s_ind  = m_dmd && ri;
    s_sck  = m_dmd && rs;
    s_wrap = 0;
    if (!m_dmd) begin
      m_sect  = 0;
      m_shift = 0;
    end else begin
      if (ri) m_sect = 0;
      else if (rs) begin
        m_sect = (m_sect + 1) % NSECT;
        s_wrap = (m_sect == 0);
      end
      if (rc) m_shift = (m_shift * 2 + int'(m_ddat)) % (1 << SHIFT_W);
    end
    p_dclk = m_dclk; p_dind = m_dind; p_dsck = m_dsck;
    if (!m_dmd) begin
      m_dclk = 0; m_dind = 0; m_dsck = 0; m_ddat = 0;
    end else if (rpmrWRITE) begin
      m_dclk = rpDATAI[1]; m_dind = rpDATAI[2]; m_dsck = rpDATAI[3]; m_ddat = rpDATAI[4];
    end
    if (clr || rpDRVCLR)        m_dmd = 0;
    else if (rpmrWRITE && rpDRY) m_dmd = rpDATAI[0];
  endtask

  task automatic check_all();
    int exp_mr;
    exp_mr = (m_sect << 8) | (int'(rpDFE) << 7) | (int'(rpECE) << 6) | (int'(m_ddat) << 4)
           | (int'(m_dsck) << 3) | (int'(m_dind) << 2) | (int'(m_dclk) << 1) | int'(m_dmd);
    chk("rpMR", 32'(rpMR), exp_mr);
    chk("rpDSECT", 32'(rpDSECT), m_sect);
    chk("rpDSHIFT", 32'(rpDSHIFT), m_shift);
    chk("strobes", 32'({rpDCLKP, rpDINDP, rpDSCKP, rpDWRAP}), 32'({s_clk, s_ind, s_sck, s_wrap}));
    n_clkp += int'(rpDCLKP);
    n_wrap += int'(rpDWRAP);
  endtask

  task automatic cyc(input bit wr, input logic [7:0] d, input bit dry = 1,
                     input bit cl = 0, input bit dc = 0, input bit rn = 1);
    rpmrWRITE = wr;
    rpDATAI   = {28'($urandom), d};
    rpDRY     = dry;
    clr       = cl;
    rpDRVCLR  = dc;
    rst_n     = rn;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] pat;
    logic [7:0]  rd;
    bit          b;
    rpDFE = 0; rpECE = 0;
    n_clkp = 0; n_wrap = 0;

    // Reset state
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    chk("reset_mr", 32'(rpMR), 32'h0000);
    chk("reset_strobes", 32'({rpDCLKP, rpDINDP, rpDSCKP, rpDWRAP}), 0);

    // DMD gating
    cyc(1, 8'h1F, 0);
    chk("nodry_mr", 32'(rpMR), 32'h0000);
    cyc(1, 8'h01, 1);
    chk("dmd_set_mr", 32'(rpMR), 32'h0001);
    cyc(1, 8'h1F, 1);
    chk("dmd_load_low", 32'(rpMR[4:0]), 32'h1F);
    chk("dmd_set_nostrobe", 32'({rpDCLKP, rpDINDP, rpDSCKP, rpDWRAP}), 0);
    cyc(0, 8'h00);
    cyc(1, 8'h01);

    // Shift pattern 1,0,1,0,... -> 0xAAAA
    n_clkp = 0;
    for (int i = 0; i < 16; i++) begin
      b = (i % 2 == 0);
      cyc(1, 8'h03 | (8'(b) << 4));
      cyc(1, 8'h01 | (8'(b) << 4));
    end
    cyc(0, 8'h00);
    chk("shift_aaaa", 32'(rpDSHIFT), 32'hAAAA);
    chk("shift_pulses", n_clkp, 16);

    // Sector count and wrap
    cyc(1, 8'h05);
    cyc(1, 8'h01);
    n_wrap = 0;
    for (int k = 1; k <= NSECT; k++) begin
      cyc(1, 8'h09);
      cyc(1, 8'h01);
      chk("sect_count", 32'(rpDSECT), k % NSECT);
      chk("wrap_edge", 32'(rpDWRAP), (k == NSECT) ? 1 : 0);
    end
    chk("wrap_once", n_wrap, 1);
    chk("wrap_mr_hi", 32'(rpMR[15:8]), 0);

    // Simultaneous index and sector edges
    cyc(1, 8'h05);
    cyc(1, 8'h01);
    for (int k = 0; k < 7; k++) begin
      cyc(1, 8'h09);
      cyc(1, 8'h01);
    end
    chk("sim_pre_sect", 32'(rpDSECT), 7);
    cyc(1, 8'h0D);
    cyc(0, 8'h00);
    chk("sim_sect", 32'(rpDSECT), 0);
    chk("sim_strobes", 32'({rpDINDP, rpDSCKP, rpDWRAP}), 32'b110);
    cyc(0, 8'h00);
    chk("sim_single", 32'({rpDINDP, rpDSCKP}), 0);

    // Clear priority over a write, with edges in flight
    cyc(1, 8'h01);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 8'h09);
      cyc(1, 8'h01);
    end
    cyc(1, 8'h0B, 1, 0, 1);
    chk("clr_dmd", 32'(rpMR[0]), 0);
    cyc(0, 8'h00);
    chk("clr_sect", 32'(rpDSECT), 0);
    chk("clr_shift", 32'(rpDSHIFT), 0);
    chk("clr_nostrobe", 32'({rpDCLKP, rpDINDP, rpDSCKP, rpDWRAP}), 0);

    // Reset mid-operation with a clock edge pending
    cyc(1, 8'h01);
    pat = 16'h1234;
    for (int i = 15; i >= 0; i--) begin
      b = pat[i];
      cyc(1, 8'h03 | (8'(b) << 4));
      cyc(1, 8'h01 | (8'(b) << 4));
    end
    cyc(1, 8'h05);
    cyc(1, 8'h01);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 8'h09);
      cyc(1, 8'h01);
    end
    chk("pre_rst_shift", 32'(rpDSHIFT), 32'h1234);
    chk("pre_rst_sect", 32'(rpDSECT), 5);
    cyc(1, 8'h03);
    rpDFE = 1; rpECE = 1;
    cyc(0, 8'h00, 1, 0, 0, 0);
    chk("rst_mr", 32'(rpMR), 32'h00C0);
    chk("rst_sect", 32'(rpDSECT), 0);
    chk("rst_shift", 32'(rpDSHIFT), 0);
    chk("rst_strobes", 32'({rpDCLKP, rpDINDP, rpDSCKP, rpDWRAP}), 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00);
    chk("post_rst_strobes", 32'({rpDCLKP, rpDINDP, rpDSCKP, rpDWRAP}), 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rpDFE = 1'($urandom);
      rpECE = 1'($urandom);
      rd    = 8'($urandom);
      rd[0] = ($urandom_range(7) != 0);
      cyc(($urandom_range(3) != 0), rd, ($urandom_range(9) != 0),
          ($urandom_range(49) == 0), ($urandom_range(49) == 0),
          ($urandom_range(99) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
